// File: rtl/lcd_8080_rx.sv
`default_nettype none
// lcd_8080_rx: responder end of a 16-bit 8080-style LCD bus. It decodes commands,
// tracks the CASET/PASET window, emits MEMWR pixels with coordinates and answers RDID reads.
module lcd_8080_rx #(
    parameter int          H_RES       = 240,
    parameter int          V_RES       = 320,
    parameter logic [15:0] ID_VALUE    = 16'h9341,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        lcd_cs,
    input  logic        lcd_rs,
    input  logic        lcd_wr,
    input  logic        lcd_rd,
    input  logic        lcd_rst,
    input  logic [15:0] lcd_data_in,
    output logic [15:0] lcd_data_out,
    output logic        lcd_data_oe,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        frame_done,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CASET = 3'd1,
        S_PASET = 3'd2,
        S_MEMWR = 3'd3,
        S_RDID  = 3'd4
    } state_t;

    localparam logic [8:0] XE_DEF   = 9'(H_RES - 1);
    localparam logic [8:0] YE_DEF   = 9'(V_RES - 1);
    // Idle level of {cs, rs, wr, rd, rst} as held in the synchronizers.
    localparam logic [4:0] CTL_IDLE = 5'b10111;

    logic [4:0]  ctl_q [SYNC_STAGES];
    logic [15:0] dat_q [SYNC_STAGES];

    logic cs_s, rs_s, wr_s, rd_s, rst_s;
    logic [15:0] data_s;
    assign {cs_s, rs_s, wr_s, rd_s, rst_s} = ctl_q[SYNC_STAGES-1];
    assign data_s = dat_q[SYNC_STAGES-1];

    logic        wr_prev_q, rd_prev_q, ovl_prev_q, rd_bad_q;
    logic        ev_wr_q, ev_ovl_q, ev_rs_q;
    logic [15:0] ev_data_q;

    logic w_ovl, w_wr_rise, w_rd_up, w_rd_rise;
    assign w_ovl     = !cs_s && !wr_s && !rd_s;
    assign w_wr_rise = !cs_s && wr_s && !wr_prev_q;
    assign w_rd_up   = rd_s && !rd_prev_q;
    assign w_rd_rise = w_rd_up && !cs_s && !rd_bad_q;

    // Front end: synchronizers plus one registered event stage ahead of the decoder.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ctl_q[i] <= CTL_IDLE;
                dat_q[i] <= 16'h0000;
            end
            wr_prev_q  <= 1'b1;
            rd_prev_q  <= 1'b1;
            ovl_prev_q <= 1'b0;
            rd_bad_q   <= 1'b0;
            ev_wr_q    <= 1'b0;
            ev_ovl_q   <= 1'b0;
            ev_rs_q    <= 1'b0;
            ev_data_q  <= 16'h0000;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                ctl_q[i] <= ctl_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            ctl_q[0]   <= {lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst};
            dat_q[0]   <= lcd_data_in;
            wr_prev_q  <= wr_s;
            rd_prev_q  <= rd_s;
            ovl_prev_q <= w_ovl;
            if (w_rd_up) begin
                rd_bad_q <= 1'b0;
            end else if (w_ovl) begin
                rd_bad_q <= 1'b1;
            end
            ev_wr_q   <= w_wr_rise && rst_s;
            ev_ovl_q  <= w_ovl && !ovl_prev_q && rst_s;
            ev_rs_q   <= rs_s;
            ev_data_q <= data_s;
        end
    end

    state_t      state_q;
    logic [1:0]  param_cnt_q;
    logic        p_sh_q, p_eh_q;
    logic [7:0]  p_sl_q;
    logic [8:0]  xs_q, xe_q, ys_q, ye_q, cur_x_q, cur_y_q;
    logic [2:0]  rd_idx_q;

    logic w_in_range;
    assign w_in_range = (int'({23'd0, cur_x_q}) < H_RES) && (int'({23'd0, cur_y_q}) < V_RES);

    function automatic logic [15:0] rdid_word(input logic [2:0] idx);
        case (idx)
            3'd2:    return {8'h00, ID_VALUE[15:8]};
            3'd3:    return {8'h00, ID_VALUE[7:0]};
            default: return 16'h0000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            param_cnt_q  <= 2'd0;
            p_sh_q       <= 1'b0;
            p_sl_q       <= 8'h00;
            p_eh_q       <= 1'b0;
            xs_q         <= 9'd0;
            xe_q         <= XE_DEF;
            ys_q         <= 9'd0;
            ye_q         <= YE_DEF;
            cur_x_q      <= 9'd0;
            cur_y_q      <= 9'd0;
            rd_idx_q     <= 3'd0;
            lcd_data_out <= 16'h0000;
            lcd_data_oe  <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_code     <= 8'h00;
            pix_valid    <= 1'b0;
            pix_x        <= 9'd0;
            pix_y        <= 9'd0;
            pix_data     <= 16'h0000;
            frame_done   <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            cmd_valid    <= 1'b0;
            pix_valid    <= 1'b0;
            frame_done   <= 1'b0;
            bus_err      <= 1'b0;
            lcd_data_oe  <= !cs_s && !rd_s;
            lcd_data_out <= (state_q == S_RDID) ? rdid_word(rd_idx_q) : 16'h0000;

            if (!rst_s) begin
                state_q     <= S_IDLE;
                param_cnt_q <= 2'd0;
                xs_q        <= 9'd0;
                xe_q        <= XE_DEF;
                ys_q        <= 9'd0;
                ye_q        <= YE_DEF;
                rd_idx_q    <= 3'd0;
            end else begin
                if (w_rd_rise && rd_idx_q != 3'd4) begin
                    rd_idx_q <= rd_idx_q + 3'd1;
                end
                if (ev_ovl_q) begin
                    bus_err <= 1'b1;
                end

                if (ev_wr_q && !ev_rs_q) begin
                    cmd_code    <= ev_data_q[7:0];
                    cmd_valid   <= 1'b1;
                    param_cnt_q <= 2'd0;
                    case (ev_data_q[7:0])
                        8'h2A: state_q <= S_CASET;
                        8'h2B: state_q <= S_PASET;
                        8'h2C: begin
                            state_q <= S_MEMWR;
                            cur_x_q <= xs_q;
                            cur_y_q <= ys_q;
                        end
                        8'hD3: begin
                            state_q  <= S_RDID;
                            rd_idx_q <= 3'd0;
                        end
                        8'h01: begin
                            state_q <= S_IDLE;
                            xs_q    <= 9'd0;
                            xe_q    <= XE_DEF;
                            ys_q    <= 9'd0;
                            ye_q    <= YE_DEF;
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end else if (ev_wr_q) begin
                    case (state_q)
                        S_CASET, S_PASET: begin
                            case (param_cnt_q)
                                2'd0: p_sh_q <= ev_data_q[0];
                                2'd1: p_sl_q <= ev_data_q[7:0];
                                2'd2: p_eh_q <= ev_data_q[0];
                                default: begin
                                    if (state_q == S_CASET) begin
                                        xs_q <= {p_sh_q, p_sl_q};
                                        xe_q <= {p_eh_q, ev_data_q[7:0]};
                                    end else begin
                                        ys_q <= {p_sh_q, p_sl_q};
                                        ye_q <= {p_eh_q, ev_data_q[7:0]};
                                    end
                                    state_q <= S_IDLE;
                                end
                            endcase
                            param_cnt_q <= param_cnt_q + 2'd1;
                        end
                        S_MEMWR: begin
                            if (w_in_range) begin
                                pix_valid <= 1'b1;
                                pix_x     <= cur_x_q;
                                pix_y     <= cur_y_q;
                                pix_data  <= ev_data_q;
                            end else begin
                                bus_err <= 1'b1;
                            end
                            // A start column past the end column runs the 9-bit counter round to xe.
                            if (cur_x_q == xe_q) begin
                                cur_x_q <= xs_q;
                                if (cur_y_q == ye_q) begin
                                    cur_y_q    <= ys_q;
                                    frame_done <= 1'b1;
                                end else begin
                                    cur_y_q <= cur_y_q + 9'd1;
                                end
                            end else begin
                                cur_x_q <= cur_x_q + 9'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire
